// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two-requester round-robin write arbiter for a register file, with zero-fill clear sweep
// Ports: Clock/Reset (sync, active-low); ReqA/B, AddrA/B, WDataA/B in, AckA/B out (one-cycle accept pulse);
//        ClrReq starts a zero-fill sweep; EnWri/WriAdd/DataI drive the register-file write port; Busy marks a sweep.
module regfile_write_arbiter #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] WDataA,
    input  logic [DATA_W-1:0] WDataB,
    output logic              AckA,
    output logic              AckB,
    input  logic              ClrReq,
    output logic              EnWri,
    output logic [ADDR_W-1:0] WriAdd,
    output logic [DATA_W-1:0] DataI,
    output logic              Busy
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state;
    logic [ADDR_W-1:0] sweepCnt;
    logic favourB;
    logic eligA, eligB, grantA, grantB;
    // a requester whose ack is on the wire this cycle is still holding the old request
    assign eligA  = ReqA & ~AckA;
    assign eligB  = ReqB & ~AckB;
    assign grantB = eligB & (~eligA | favourB);
    assign grantA = eligA & ~grantB;
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= CLEAR_ON_RESET ? CLEAR : RUN;
            Busy     <= CLEAR_ON_RESET;
            EnWri    <= 1'b0;
            WriAdd   <= '0;
            DataI    <= '0;
            AckA     <= 1'b0;
            AckB     <= 1'b0;
            sweepCnt <= '0;
            favourB  <= 1'b0;
        end else if (state == CLEAR) begin
            EnWri    <= 1'b1;
            WriAdd   <= sweepCnt;
            DataI    <= '0;
            AckA     <= 1'b0;
            AckB     <= 1'b0;
            Busy     <= 1'b1;
            favourB  <= 1'b0;
            sweepCnt <= sweepCnt + 1'b1;
            // the last sweep write is issued on the same edge that returns to RUN
            if (sweepCnt == '1) state <= RUN;
        end else if (ClrReq) begin
            state    <= CLEAR;
            sweepCnt <= '0;
            EnWri    <= 1'b0;
            AckA     <= 1'b0;
            AckB     <= 1'b0;
            Busy     <= 1'b1;
            favourB  <= 1'b0;
        end else begin
            EnWri <= grantA | grantB;
            AckA  <= grantA;
            AckB  <= grantB;
            Busy  <= 1'b0;
            if (grantA | grantB) begin
                WriAdd  <= grantA ? AddrA : AddrB;
                DataI   <= grantA ? WDataA : WDataB;
                favourB <= grantA;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: randomized and directed checks of regfile_write_arbiter against a cycle-level reference model
module tb_regfile_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 32;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic ReqA = 1'b0, ReqB = 1'b0, ClrReq = 1'b0;
    logic [AW-1:0] AddrA = '0, AddrB = '0;
    logic [DW-1:0] WDataA = '0, WDataB = '0;
    logic AckA, AckB, EnWri, Busy;
    logic [AW-1:0] WriAdd;
    logic [DW-1:0] DataI;
    logic AckA1, AckB1, EnWri1, Busy1;
    logic [AW-1:0] WriAdd1;
    logic [DW-1:0] DataI1;
    int total = 0;
    int passed = 0;
    logic [DW-1:0] rf [NREG];
    // reference model: expected outputs plus abstract progress state
    logic mEn, mAckA, mAckB, mBusy;
    logic [AW-1:0] mAdd;
    logic [DW-1:0] mData;
    bit mClearing;
    int mSweep;
    int mLast;
    always #5 Clock = ~Clock;
    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .Clock(Clock), .Reset(Reset), .ReqA(ReqA), .ReqB(ReqB), .AddrA(AddrA), .AddrB(AddrB),
        .WDataA(WDataA), .WDataB(WDataB), .AckA(AckA), .AckB(AckB), .ClrReq(ClrReq),
        .EnWri(EnWri), .WriAdd(WriAdd), .DataI(DataI), .Busy(Busy));
    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) dutNc (
        .Clock(Clock), .Reset(Reset), .ReqA(ReqA), .ReqB(ReqB), .AddrA(AddrA), .AddrB(AddrB),
        .WDataA(WDataA), .WDataB(WDataB), .AckA(AckA1), .AckB(AckB1), .ClrReq(ClrReq),
        .EnWri(EnWri1), .WriAdd(WriAdd1), .DataI(DataI1), .Busy(Busy1));
    function automatic logic [40:0] obs();
        return {EnWri, WriAdd, DataI, AckA, AckB, Busy};
    endfunction
    function automatic logic [40:0] expv();
        return {mEn, mAdd, mData, mAckA, mAckB, mBusy};
    endfunction
    // one edge of the reference behaviour, from the inputs present at that edge
    task automatic modelStep();
        bit eA, eB, pA, pB;
        if (!Reset) begin
            {mEn, mAckA, mAckB} = '0;
            mAdd = '0;
            mData = '0;
            mLast = 0;
            mSweep = 0;
            mClearing = 1;
            mBusy = 1'b1;
        end else if (mClearing) begin
            mEn = 1'b1;
            mAdd = AW'(mSweep);
            mData = '0;
            {mAckA, mAckB} = '0;
            mBusy = 1'b1;
            mSweep++;
            if (mSweep == NREG) begin
                mClearing = 0;
                mLast = 0;
            end
        end else if (ClrReq) begin
            mClearing = 1;
            mSweep = 0;
            {mEn, mAckA, mAckB} = '0;
            mBusy = 1'b1;
            mLast = 0;
        end else begin
            eA = ReqA && !mAckA;
            eB = ReqB && !mAckB;
            pB = eB && (!eA || mLast == 1);
            pA = eA && !pB;
            mBusy = 1'b0;
            mAckA = pA;
            mAckB = pB;
            mEn = pA || pB;
            if (pA) begin
                mAdd = AddrA;
                mData = WDataA;
                mLast = 1;
            end else if (pB) begin
                mAdd = AddrB;
                mData = WDataB;
                mLast = 2;
            end
        end
    endtask
    task automatic tick();
        @(posedge Clock);
        modelStep();
        #1;
        if (EnWri === 1'b1) rf[WriAdd] = DataI;
    endtask
    task automatic test_reset();
        ReqA = 0; ReqB = 0; ClrReq = 0; Reset = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs() !== expv() || EnWri !== 1'b0 || Busy !== 1'b1 || WriAdd !== '0 || DataI !== '0)
                $display("FAIL reset_state cyc %0d: got %h want %h", i, obs(), expv());
            else passed++;
        end
        Reset = 1;
        for (int i = 0; i < NREG; i++) begin
            tick();
            total++;
            if (obs() !== expv() || EnWri !== 1'b1 || WriAdd !== AW'(i) || DataI !== '0 || Busy !== 1'b1)
                $display("FAIL reset_sweep addr %0d: got %h want %h", i, obs(), expv());
            else passed++;
        end
        tick();
        total++;
        if (obs() !== expv() || Busy !== 1'b0 || EnWri !== 1'b0)
            $display("FAIL sweep_end: got %h want %h", obs(), expv());
        else passed++;
    endtask
    task automatic test_single();
        ReqA = 1; AddrA = 3; WDataA = 32'h5;
        tick();
        total++;
        if (obs() !== expv() || {EnWri, WriAdd, DataI, AckA} !== {1'b1, 5'd3, 32'h5, 1'b1})
            $display("FAIL single_write: got %h want %h", obs(), expv());
        else passed++;
        tick();
        total++;
        if (obs() !== expv() || EnWri !== 1'b0 || AckA !== 1'b0)
            $display("FAIL single_no_double: got %h want %h", obs(), expv());
        else passed++;
        ReqA = 0;
        tick();
    endtask
    task automatic test_back_to_back();
        Reset = 0;
        tick();
        Reset = 1;
        ReqA = 1; AddrA = 1; WDataA = 10;
        ReqB = 1; AddrB = 2; WDataB = 20;
        repeat (NREG) tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (obs() !== expv() || AckA !== (i % 2 == 0) || AckB !== (i % 2 == 1) || EnWri !== 1'b1 ||
                WriAdd !== ((i % 2 == 0) ? 5'd1 : 5'd2) || DataI !== ((i % 2 == 0) ? 32'd10 : 32'd20))
                $display("FAIL alternate grant %0d: got %h want %h", i, obs(), expv());
            else passed++;
        end
        ReqA = 0; ReqB = 0;
        tick();
    endtask
    task automatic test_clear();
        ReqB = 1; AddrB = 4; WDataB = 44; ClrReq = 1;
        tick();
        ClrReq = 0;
        total++;
        if (obs() !== expv() || AckB !== 1'b0 || EnWri !== 1'b0 || Busy !== 1'b1)
            $display("FAIL clear_entry: got %h want %h", obs(), expv());
        else passed++;
        for (int i = 0; i < NREG; i++) begin
            ClrReq = (i == 10);
            tick();
            total++;
            if (obs() !== expv() || AckB !== 1'b0 || EnWri !== 1'b1 || WriAdd !== AW'(i) || DataI !== '0)
                $display("FAIL clear_sweep addr %0d: got %h want %h", i, obs(), expv());
            else passed++;
        end
        ClrReq = 0;
        tick();
        total++;
        if (obs() !== expv() || {AckB, EnWri, WriAdd, DataI, Busy} !== {1'b1, 1'b1, 5'd4, 32'd44, 1'b0})
            $display("FAIL clear_then_ackB: got %h want %h", obs(), expv());
        else passed++;
        ReqB = 0;
        tick();
    endtask
    task automatic test_reset_mid_sweep();
        ClrReq = 1;
        tick();
        ClrReq = 0;
        repeat (18) tick();
        total++;
        if (obs() !== expv() || WriAdd !== 5'd17)
            $display("FAIL mid_sweep_pos: got %h want %h", obs(), expv());
        else passed++;
        ReqA = 1; AddrA = 6; WDataA = 66;
        Reset = 0;
        tick();
        Reset = 1;
        for (int i = 0; i < NREG; i++) begin
            tick();
            total++;
            if (obs() !== expv() || WriAdd !== AW'(i) || EnWri !== 1'b1 || AckA !== 1'b0)
                $display("FAIL restart_sweep addr %0d: got %h want %h", i, obs(), expv());
            else passed++;
        end
        tick();
        total++;
        if (obs() !== expv() || {AckA, WriAdd, DataI} !== {1'b1, 5'd6, 32'd66})
            $display("FAIL rearbitrate_after_reset: got %h want %h", obs(), expv());
        else passed++;
        ReqA = 0;
        tick();
    endtask
    task automatic test_no_clear();
        ReqA = 0; ReqB = 1; AddrB = 7; WDataB = 77;
        Reset = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({Busy1, EnWri1, AckB1, WriAdd1, DataI1} !== {3'b000, 5'd0, 32'd0})
                $display("FAIL noclear_reset cyc %0d: busy %b en %b ack %b", i, Busy1, EnWri1, AckB1);
            else passed++;
        end
        Reset = 1;
        tick();
        total++;
        if ({Busy1, EnWri1, AckB1, WriAdd1, DataI1} !== {3'b011, 5'd7, 32'd77})
            $display("FAIL noclear_first_grant: busy %b en %b ack %b add %0d data %0d", Busy1, EnWri1, AckB1, WriAdd1, DataI1);
        else passed++;
        ReqB = 0;
        tick();
        total++;
        if ({Busy1, EnWri1, AckB1} !== 3'b000)
            $display("FAIL noclear_idle: busy %b en %b ack %b", Busy1, EnWri1, AckB1);
        else passed++;
        repeat (NREG) tick();
    endtask
    task automatic test_same_addr();
        ReqA = 1; AddrA = 9; WDataA = 1;
        ReqB = 1; AddrB = 9; WDataB = 2;
        tick();
        total++;
        if (obs() !== expv() || AckA !== 1'b1)
            $display("FAIL same_addr_A: got %h want %h", obs(), expv());
        else passed++;
        ReqA = 0;
        tick();
        total++;
        if (obs() !== expv() || AckB !== 1'b1)
            $display("FAIL same_addr_B: got %h want %h", obs(), expv());
        else passed++;
        ReqB = 0;
        tick();
        total++;
        if (rf[9] !== 32'd2)
            $display("FAIL same_addr_final: reg9 %0d want 2", rf[9]);
        else passed++;
    endtask
    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 1500; c++) begin
            Reset = ($urandom_range(199) != 0);
            ClrReq = ($urandom_range(59) == 0);
            tick();
            total++;
            if (obs() !== expv()) begin
                errs++;
                if (errs < 10) $display("FAIL random cyc %0d: got %h want %h", c, obs(), expv());
            end else passed++;
            if (AckA === 1'b1) ReqA = 0;
            if (AckB === 1'b1) ReqB = 0;
            if (!ReqA && $urandom_range(1) == 1) begin
                ReqA = 1; AddrA = AW'($urandom); WDataA = $urandom;
            end
            if (!ReqB && $urandom_range(1) == 1) begin
                ReqB = 1; AddrB = AW'($urandom); WDataB = $urandom;
            end
        end
        Reset = 1; ClrReq = 0; ReqA = 0; ReqB = 0;
    endtask
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_clear();
        test_reset_mid_sweep();
        test_no_clear();
        test_same_addr();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
